// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall controller.
// The master side is the pipeline (hazard unit, EX, exception logic);
// the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned STAT_W = 32
);
   logic              id_stallreq_i;
   logic              ex_mc_start_i;
   logic [CNT_W-1:0]  ex_mc_cycles_i;
   logic              flush_i;
   logic [5:0]        stall_o;
   logic              ex_mc_done_o;
   logic              mc_busy_o;
   logic [STAT_W-1:0] stall_cnt_o;

   modport master (
      output id_stallreq_i,
      output ex_mc_start_i,
      output ex_mc_cycles_i,
      output flush_i,
      input  stall_o,
      input  ex_mc_done_o,
      input  mc_busy_o,
      input  stall_cnt_o
   );

   modport slave (
      input  id_stallreq_i,
      input  ex_mc_start_i,
      input  ex_mc_cycles_i,
      input  flush_i,
      output stall_o,
      output ex_mc_done_o,
      output mc_busy_o,
      output stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline stall controller: merges the ID load-use stall with a
// multi-cycle EX sequencer, handles flush, and counts stalled cycles.
// Outputs react to the current-cycle request, so they are decoded from the
// registered state plus inputs rather than registered themselves.
module pipe_ctrl #(
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned STAT_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_ID   = 6'b000111;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [STAT_W-1:0] r_stall_cnt;

   logic              w_start_long;
   logic              w_start_two;
   logic              w_start_short;
   logic              w_ex_stall;
   logic              w_done_raw;
   logic [5:0]        w_stall;
   logic              w_done;
   logic              w_busy;
   logic              w_stat_sat;

   // Classify a start request seen in IDLE by its occupancy length.
   always_comb begin
      w_start_long  = 1'b0;
      w_start_two   = 1'b0;
      w_start_short = 1'b0;
      if (r_state == S_IDLE && bus.ex_mc_start_i) begin
         if (bus.ex_mc_cycles_i > CNT_TWO)
            w_start_long = 1'b1;
         else if (bus.ex_mc_cycles_i == CNT_TWO)
            w_start_two = 1'b1;
         else
            w_start_short = 1'b1;
      end
   end

   // EX stall and done pulse before flush/reset gating.
   always_comb begin
      w_ex_stall = w_start_long || w_start_two || (r_state == S_BUSY);
      w_done_raw = w_start_short || (r_state == S_DONE);
   end

   // Stall vector priority: reset, flush, EX hold, then ID load-use.
   always_comb begin
      w_stall = STALL_NONE;
      if (rst || bus.flush_i)
         w_stall = STALL_NONE;
      else if (w_ex_stall)
         w_stall = STALL_EX;
      else if (bus.id_stallreq_i)
         w_stall = STALL_ID;
   end

   // Done/busy status, forced low while in reset; flush also kills done.
   always_comb begin
      w_done = w_done_raw && !rst && !bus.flush_i;
      w_busy = (r_state != S_IDLE) && !rst;
   end

   assign w_stat_sat = (r_stall_cnt == '1);

   // Sequencer: tracks remaining EX occupancy of the current multi-cycle op.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else if (bus.flush_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start_long) begin
                  r_cnt   <= bus.ex_mc_cycles_i - CNT_TWO;
                  r_state <= S_BUSY;
               end else if (w_start_two) begin
                  r_state <= S_DONE;
               end
            end
            S_BUSY: begin
               if (r_cnt == CNT_ONE)
                  r_state <= S_DONE;
               else
                  r_cnt <= r_cnt - CNT_ONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which any stage was held.
   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_stall != STALL_NONE && !w_stat_sat)
         r_stall_cnt <= r_stall_cnt + STAT_W'(1);
   end

   assign bus.stall_o      = w_stall;
   assign bus.ex_mc_done_o = w_done;
   assign bus.mc_busy_o    = w_busy;
   assign bus.stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared against an occupancy-based reference model.
module tb_pipe_ctrl;

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned STAT_W = 32;

   logic clk;
   logic rst;

   int n_checks;
   int n_errors;

   // Reference model: remaining cycles of the op in EX after this one
   // (0 = nothing in flight), plus the saturating stall statistic.
   int               m_rem;
   logic [STAT_W-1:0] m_cnt;

   pipe_ctrl_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

   pipe_ctrl #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check the
   // settled outputs, then advance the model to the following cycle.
   task automatic step(input logic r, input logic idr, input logic st,
                       input logic [CNT_W-1:0] n, input logic fl, input string tag);
      logic [5:0] es;
      logic       ed;
      logic       eb;
      logic       ex_st;
      int         nrem;
      @(negedge clk);
      rst                = r;
      bus.id_stallreq_i  = idr;
      bus.ex_mc_start_i  = st;
      bus.ex_mc_cycles_i = n;
      bus.flush_i        = fl;
      #1;
      es    = 6'b000000;
      ed    = 1'b0;
      eb    = 1'b0;
      ex_st = 1'b0;
      nrem  = 0;
      if (!r) begin
         eb   = (m_rem != 0);
         nrem = m_rem;
         if (m_rem == 0) begin
            if (st && int'(n) >= 2) begin
               ex_st = 1'b1;
               nrem  = int'(n) - 1;
            end else if (st) begin
               ed = 1'b1;
            end
         end else if (m_rem == 1) begin
            ed   = 1'b1;
            nrem = 0;
         end else begin
            ex_st = 1'b1;
            nrem  = m_rem - 1;
         end
         if (fl) begin
            ed   = 1'b0;
            nrem = 0;
         end else if (ex_st) begin
            es = 6'b001111;
         end else if (idr) begin
            es = 6'b000111;
         end
      end
      check({tag, ".stall"}, 32'(bus.stall_o), 32'(es));
      check({tag, ".done"},  32'(bus.ex_mc_done_o), 32'(ed));
      check({tag, ".busy"},  32'(bus.mc_busy_o), 32'(eb));
      check({tag, ".scnt"},  bus.stall_cnt_o, m_cnt);
      if (r) begin
         m_rem = 0;
         m_cnt = '0;
      end else begin
         m_rem = nrem;
         if (es != 6'b000000 && m_cnt != '1)
            m_cnt = m_cnt + 1;
      end
   endtask

   task automatic idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++)
         step(1'b0, 1'b0, 1'b0, '0, 1'b0, tag);
   endtask

   initial begin
      n_checks           = 0;
      n_errors           = 0;
      m_rem              = 0;
      m_cnt              = '0;
      rst                = 1'b1;
      bus.id_stallreq_i  = 1'b0;
      bus.ex_mc_start_i  = 1'b0;
      bus.ex_mc_cycles_i = '0;
      bus.flush_i        = 1'b0;

      // Reset with requests asserted: outputs must stay quiet.
      step(1'b1, 1'b1, 1'b1, 6'd5, 1'b0, "rst0");
      step(1'b1, 1'b1, 1'b1, 6'd5, 1'b0, "rst1");
      // First cycle after release with a start N=5.
      step(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, "n5s");
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, 1'b0, '0, 1'b0, "n5");

      // Long divide, N=34.
      step(1'b0, 1'b0, 1'b1, 6'd34, 1'b0, "div");
      for (int i = 0; i < 35; i++)
         step(1'b0, 1'b0, 1'b1, 6'd7, 1'b0, "div");
      idle(2, "idl");

      // Boundary lengths 2, 1, 0.
      step(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, "n2");
      step(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, "n2");
      step(1'b0, 1'b0, 1'b1, 6'd1, 1'b0, "n1");
      step(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, "n0");
      step(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, "n63");
      for (int i = 0; i < 63; i++)
         step(1'b0, 1'b0, 1'b0, '0, 1'b0, "n63");

      // Priority: ID request during BUSY, then alone in IDLE.
      step(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, "pri");
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, "pri");
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, "pri");
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, "pri");
      step(1'b0, 1'b1, 1'b0, '0, 1'b0, "pid");
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, "pid");

      // Flush on stall cycle 4 of an N=10 op, then N=3.
      step(1'b0, 1'b0, 1'b1, 6'd10, 1'b0, "fl");
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, "fl");
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, "fl");
      step(1'b0, 1'b1, 1'b1, 6'd9, 1'b1, "flx");
      step(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, "fl3");
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, "fl3");
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, "fl3");
      step(1'b0, 1'b0, 1'b0, '0, 1'b0, "fl3");

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic             r_r;
         logic             r_idr;
         logic             r_st;
         logic             r_fl;
         logic [CNT_W-1:0] r_n;
         r_r   = ($urandom_range(0, 199) == 0);
         r_idr = ($urandom_range(0, 4) == 0);
         r_st  = ($urandom_range(0, 2) == 0);
         r_fl  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0)
            r_n = CNT_W'($urandom_range(0, 63));
         else
            r_n = CNT_W'($urandom_range(0, 5));
         step(r_r, r_idr, r_st, r_n, r_fl, "rnd");
      end

      // Saturation of the stall statistic.
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, "sat");
      idle(2, "sat");
      force dut.r_stall_cnt = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_stall_cnt;
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 1'b0, '0, 1'b0, "sat");
      check("sat.final", bus.stall_cnt_o, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline stall controller for the 5-stage MIPS core. It merges the ID load-use stall request with a multi-cycle EX operation sequencer (divide, multiply-accumulate) that holds EX for a programmable number of cycles. It drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also handles pipeline flush and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
CNT_W, 6, width of multi-cycle length input and internal down-counter
STAT_W, 32, width of stall statistics counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
id_stallreq_i  input  1  ID load-use hazard request (stall PC/IF/ID one cycle)
ex_mc_start_i  input  1  EX holds a multi-cycle op this cycle (level, sampled only in IDLE)
ex_mc_cycles_i  input  CNT_W  total EX occupancy N of the op, in cycles
flush_i  input  1  pipeline flush (exception/branch annul); cancels any multi-cycle op
stall_o  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
ex_mc_done_o  output  1  EX result valid; EX may latch result this cycle
mc_busy_o  output  1  sequencer not IDLE
stall_cnt_o  output  STAT_W  cycles with stall_o != 0, saturating

Behaviour:
- States: IDLE, BUSY, DONE; internal cnt[CNT_W-1:0].
- Reset (rst=1 at edge): state<=IDLE, cnt<=0, stall_cnt_o<=0. While rst=1, stall_o=6'b000000, ex_mc_done_o=0, mc_busy_o=0 (outputs gated combinationally).
- IDLE:
  - ex_mc_start_i=1, N>=3: EX stall this cycle; cnt<=N-2; next BUSY.
  - ex_mc_start_i=1, N==2: EX stall this cycle; next DONE.
  - ex_mc_start_i=1, N<=1: single-cycle; no EX stall; ex_mc_done_o=1 this cycle; stay IDLE.
  - Otherwise: stay IDLE.
- BUSY:
  - EX stall every cycle.
  - cnt==1: next DONE. Otherwise cnt<=cnt-1.
  - ex_mc_start_i and ex_mc_cycles_i are ignored.
- DONE:
  - No EX stall; ex_mc_done_o=1 for exactly this cycle; next IDLE.
  - ex_mc_start_i is ignored (the same instruction is leaving EX).
- Occupancy rule: an op with N>=2 occupies EX exactly N cycles, with N-1 stall cycles, and ex_mc_done_o is high in cycle N.
- stall_o priority (combinational):
  - flush_i=1: 6'b000000.
  - EX stall: 6'b001111.
  - id_stallreq_i=1: 6'b000111.
  - Otherwise: 6'b000000.
  - An ID request during an EX stall is subsumed and not queued.
- flush_i=1 in any state: state<=IDLE, cnt<=0, ex_mc_done_o=0 this cycle. A start coincident with flush is discarded.
- mc_busy_o = (state != IDLE).
- stall_cnt_o: increments by 1 on every non-reset cycle with stall_o != 0. It holds at all-ones and never wraps.
- Width: cnt arithmetic is unsigned CNT_W. The maximum N is 2^CNT_W-1 (63 by default).

Test Plan:
- Reset: rst=1 for 2 cycles with id_stallreq_i=1 and ex_mc_start_i=1 -> stall_o=0, done=0, busy=0, stall_cnt_o=0; first cycle after release with start, N=5 -> stall_o=6'b001111.
- Divide N=34: start in IDLE -> stall_o=6'b001111 for 33 consecutive cycles, done=1 on cycle 34 with stall_o=0, busy low the next cycle, stall_cnt_o=33.
- Boundaries: N=2 -> one stall cycle then done; N=1 and N=0 -> done same cycle, no stall, state stays IDLE.
- Priority: id_stallreq_i=1 during BUSY -> stall_o=6'b001111. id_stallreq_i=1 in IDLE without start -> 6'b000111 for that cycle only.
- Flush: N=10, flush_i=1 on stall cycle 4 -> stall_o=0 that cycle, no done pulse, busy=0 next cycle. A new start (N=3) right after -> 2 stall cycles then done.
- Saturation: preload stall_cnt to 32'hFFFFFFFE (force), 3 stall cycles -> stall_cnt_o reads FFFFFFFF and holds.
